// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and size helper for the load/store unit
package lsu_pkg;

    localparam int LSU_BUS_BITS = 64;
    localparam int LSU_TAG_BITS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;
    localparam logic [2:0] FUNCT3_SD  = 3'b011;

    // Access width in bytes: 1/2/4/8 from the low two funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request, data-memory and response signals of the load/store unit
interface lsu_if #(
    parameter int BUS_BITS = 64,
    parameter int TAG_BITS = 5
);
    logic                req_valid;
    logic                req_ready;
    logic                req_store;
    logic [2:0]          req_funct3;
    logic [BUS_BITS-1:0] req_addr;
    logic [BUS_BITS-1:0] req_wdata;
    logic [TAG_BITS-1:0] req_tag;
    logic                mem_we;
    logic [BUS_BITS-1:0] mem_addr;
    logic [2:0]          mem_funct3;
    logic [BUS_BITS-1:0] mem_wdata;
    logic [BUS_BITS-1:0] mem_rdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [BUS_BITS-1:0] resp_data;
    logic [TAG_BITS-1:0] resp_tag;
    logic                resp_err;

    // The load/store unit itself.
    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_tag,
        input  mem_rdata, resp_ready,
        output req_ready, mem_we, mem_addr, mem_funct3, mem_wdata,
        output resp_valid, resp_data, resp_tag, resp_err
    );

    // Execute stage, data memory and writeback taken together.
    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_tag,
        output mem_rdata, resp_ready,
        input  req_ready, mem_we, mem_addr, mem_funct3, mem_wdata,
        input  resp_valid, resp_data, resp_tag, resp_err
    );
endinterface

// File: rtl/lsu_req_check.sv
// rtl/lsu_req_check.sv - request legality check; LSU_MISALIGN_TRAP_EN adds misalignment errors
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int BUS_BITS = 64
) (
    input  logic [2:0]          funct3,
    input  logic                store,
    input  logic [BUS_BITS-1:0] addr,
    output logic                err
);
    logic illegal;
    logic misalign;

    // funct3 111 never exists; stores have no unsigned variants.
    assign illegal = (funct3 == 3'b111) || (store && funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] align_mask;
    logic       unused_addr;
    assign align_mask  = 3'(size_bytes(funct3) - 4'd1);
    assign misalign    = |(addr[2:0] & align_mask);
    assign unused_addr = ^addr[BUS_BITS-1:3];
`else
    logic unused_addr;
    assign misalign    = 1'b0;
    assign unused_addr = ^addr;
`endif

    assign err = illegal || misalign;
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator; option LSU_MISALIGN_TRAP_EN
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BUS_BITS = LSU_BUS_BITS,
    parameter int TAG_BITS = LSU_TAG_BITS
) (
    input  logic   clk,
    input  logic   rst_n,
    lsu_if.master  bus
);
    lsu_state_t          state;
    lsu_state_t          state_next;
    logic                req_fire;
    logic                req_err;
    logic                r_store;
    logic [2:0]          r_funct3;
    logic [BUS_BITS-1:0] r_addr;
    logic [BUS_BITS-1:0] r_wdata;
    logic [TAG_BITS-1:0] r_tag;
    logic                r_err;
    logic [BUS_BITS-1:0] r_resp_data;

    lsu_req_check #(.BUS_BITS(BUS_BITS)) u_check (
        .funct3 (bus.req_funct3),
        .store  (bus.req_store),
        .addr   (bus.req_addr),
        .err    (req_err)
    );

    assign req_fire = (state == IDLE) && bus.req_valid;

    // State register; reset returns to IDLE at once, which also kills mem_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode: errors skip the memory, stores skip capture.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = req_err ? RESP : ACCESS;
            ACCESS:  state_next = r_store ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request register latched on accept; response data cleared then, filled on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store     <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_tag       <= '0;
            r_err       <= 1'b0;
            r_resp_data <= '0;
        end else if (req_fire) begin
            r_store     <= bus.req_store;
            r_funct3    <= bus.req_funct3;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_tag       <= bus.req_tag;
            r_err       <= req_err;
            r_resp_data <= '0;
        end else if (state == CAPTURE) begin
            r_resp_data <= bus.mem_rdata;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_we     = (state == ACCESS) && r_store && !r_err;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_funct3 = r_funct3;
    assign bus.mem_wdata  = r_wdata;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_tag   = r_tag;
    assign bus.resp_err   = r_err;
endmodule
